uart_fifo_loopback: RTL and testbench

//  Byte-echo UART: receives 8N1 serial frames on rx, buffers each byte in an RX FIFO,

---
 rtl/uart_fifo_loopback.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_fifo_loopback.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_loopback.sv
// 8N1 byte-echo UART: rx -> 2-FF sync -> oversampling receiver -> rx fifo -> tx fifo -> transmitter.
// The receiver and transmitter share one free-running baud tick.

module uart_fifo_sync #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);
  logic [7:0]  mem [2**AW];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // first-word fall-through: head byte is visible without a pop
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | counting to mid start bit, rejects glitches
// RX_DATA  | sampling 8 data bits mid-bit, LSB first
// RX_STOP  | checking stop bit; good stop pulses w_rx_done
// RX_WAIT  | framing error, waiting for line to return high
// TX_IDLE  | tx high, waiting for tx fifo data
// TX_START | driving start bit
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving stop bit; chains straight into next start
module uart_fifo_loopback #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_MID   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          rx_m, rx_s, rx_q, rx_fall;

  rx_state_t     rx_state, rx_state_n;
  logic [OW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          w_rx_done;

  tx_state_t     tx_state, tx_state_n;
  logic [OW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_byte, tx_byte_n;
  logic          tx_n, tx_pop;

  logic [7:0]    rxf_rdata, txf_rdata;
  logic          rxf_empty, rxf_full, txf_empty, txf_full, xfer;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_cnt <= '0;
    else      div_cnt <= tick ? '0 : div_cnt + DW'(1);
  end

  // sync chain resets low so a line held low across reset is not taken as a start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
      rx_q <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end
  assign rx_fall = rx_q && !rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx       <= 1'b1;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_byte  <= tx_byte_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    w_rx_done  = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_fall) begin
        rx_state_n = RX_START;
        rx_cnt_n   = '0;
      end
      RX_START: if (tick) begin
        if (rx_cnt == OS_MID) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + OW'(1);
      end
      RX_DATA: if (tick) begin
        if (rx_cnt == OS_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else rx_cnt_n = rx_cnt + OW'(1);
      end
      RX_STOP: if (tick) begin
        if (rx_cnt == OS_LAST) begin
          rx_cnt_n = '0;
          if (rx_s) begin
            w_rx_done  = 1'b1;
            rx_state_n = RX_IDLE;
          end else rx_state_n = RX_WAIT;
        end else rx_cnt_n = rx_cnt + OW'(1);
      end
      RX_WAIT: if (rx_s) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign xfer = !rxf_empty && !txf_full;

  uart_fifo_sync #(.AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_done && !rxf_full),
    .wdata (rx_shift),
    .pop   (xfer),
    .rdata (rxf_rdata),
    .empty (rxf_empty),
    .full  (rxf_full)
  );

  uart_fifo_sync #(.AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .wdata (rxf_rdata),
    .pop   (tx_pop),
    .rdata (txf_rdata),
    .empty (txf_empty),
    .full  (txf_full)
  );

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_byte_n  = tx_byte;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: if (!txf_empty) begin
        tx_pop     = 1'b1;
        tx_byte_n  = txf_rdata;
        tx_cnt_n   = '0;
        tx_state_n = TX_START;
      end
      TX_START: if (tick) begin
        if (tx_cnt == OS_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end else tx_cnt_n = tx_cnt + OW'(1);
      end
      TX_DATA: if (tick) begin
        if (tx_cnt == OS_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          else                tx_bit_n   = tx_bit + 3'd1;
        end else tx_cnt_n = tx_cnt + OW'(1);
      end
      TX_STOP: if (tick) begin
        if (tx_cnt == OS_LAST) begin
          tx_cnt_n = '0;
          if (!txf_empty) begin
            tx_pop     = 1'b1;
            tx_byte_n  = txf_rdata;
            tx_state_n = TX_START;
          end else tx_state_n = TX_IDLE;
        end else tx_cnt_n = tx_cnt + OW'(1);
      end
      default: tx_state_n = TX_IDLE;
    endcase
    case (tx_state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = tx_byte_n[tx_bit_n];
      default:  tx_n = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_fifo_loopback.sv
// Loopback bench: drives 8N1 frames on rx, decodes tx with a monitor and
// compares echoed bytes against a queue of expected bytes.

module tb_uart_fifo_loopback;
  // line rate scaled up so each bit is 64 clocks (tick divisor 4)
  localparam int CLK_HZ  = 100_000_000;
  localparam int BAUD    = 1_562_500;
  localparam int OS      = 16;
  localparam int DIV     = CLK_HZ / (BAUD * OS);
  localparam int BIT_CLK = DIV * OS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic tx;

  uart_fifo_loopback #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    int         exp_done;
    bit         exp_echo;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  longint     cyc = 0;
  logic [7:0] exp_q[$];
  longint     start_q[$];
  int         done_cnt = 0;
  longint     last_done_cyc = 0;
  bit         aborted = 1'b0;
  bit         mon_busy = 1'b0;
  logic       tx_prev = 1'b1;
  logic [7:0] mon_b;
  logic       mon_s0, mon_s1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut.w_rx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  always @(negedge rst) aborted = 1'b1;

  task automatic check(input string name, input longint act, input longint exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // tx monitor: decode each frame mid-bit and score it against exp_q
  always begin
    @(negedge clk);
    if (rst && tx_prev && !tx) begin
      mon_busy = 1'b1;
      aborted  = 1'b0;
      start_q.push_back(cyc);
      repeat (BIT_CLK / 2) @(negedge clk);
      mon_s0 = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CLK) @(negedge clk);
        mon_b[i] = tx;
      end
      repeat (BIT_CLK) @(negedge clk);
      mon_s1 = tx;
      if (!aborted) begin
        check("tx_byte_expected", exp_q.size() > 0, 1);
        check("tx_start_bit", mon_s0, 0);
        check("tx_stop_bit", mon_s1, 1);
        if (exp_q.size() > 0) check("tx_echo_byte", mon_b, exp_q.pop_front());
      end
      mon_busy = 1'b0;
    end
    tx_prev = tx;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_v, output bit got_done);
    got_done = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stop_v;
    for (int k = 0; k < 2 * BIT_CLK && !got_done; k++) begin
      @(negedge clk);
      if (dut.w_rx_done) got_done = 1'b1;
    end
    if (!stop_v) begin
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || mon_busy) && k < 40 * BIT_CLK) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (3 * BIT_CLK) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int  d0, s0;
    bit  got;
    d0 = done_cnt;
    s0 = start_q.size();
    if (v.exp_echo) exp_q.push_back(v.data);
    send_frame(v.data, v.stop_v, got);
    check({name, "_done_seen"}, got, v.exp_done > 0);
    drain(name);
    check({name, "_done_pulses"}, done_cnt - d0, v.exp_done);
    check({name, "_tx_frames"}, start_q.size() - s0, v.exp_echo);
    if (v.exp_echo && start_q.size() > s0)
      check_range({name, "_latency"}, start_q[start_q.size()-1] - last_done_cyc, 0, DIV + 6);
    check({name, "_tx_idle"}, tx, 1);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    bit   tx_low;
    bit   got;
    int   d0;
    int   k;
    vec_t v42;

    vecs[0] = '{8'h30, 1'b1, 1, 1'b1};
    vecs[1] = '{8'h55, 1'b0, 0, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 1, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 1, 1'b1};

    // reset held with idle line
    tx_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx) tx_low = 1'b1;
    end
    check("reset_tx_high", tx_low, 0);
    check("reset_no_done", done_cnt, 0);
    rst = 1'b1;
    repeat (4 * BIT_CLK) @(negedge clk);
    check("post_reset_tx_idle", tx, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d_%02h", i, vecs[i].data));

    // back-to-back burst: each next frame starts as soon as w_rx_done is seen
    start_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h30 + 8'(i), 1'b1, got);
      check($sformatf("burst%0d_done_seen", i), got, 1);
    end
    drain("burst");
    check("burst_done_pulses", done_cnt - d0, 4);
    check("burst_tx_frames", start_q.size(), 4);
    for (int i = 1; i < start_q.size(); i++)
      check_range($sformatf("burst_gap%0d", i), start_q[i] - start_q[i-1], 10 * BIT_CLK - DIV, 10 * BIT_CLK);

    // short low glitch on idle line must be rejected
    d0 = done_cnt;
    tx_low = 1'b0;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 4 * BIT_CLK; i++) begin
      @(negedge clk);
      if (!tx) tx_low = 1'b1;
    end
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_tx_high", tx_low, 0);

    // reset during echo of 0xFF: frame aborted, queued byte lost
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, got);
    check("rst_ff_done_seen", got, 1);
    k = 0;
    while (!mon_busy && k < 4 * BIT_CLK) begin
      @(negedge clk);
      k++;
    end
    check("rst_ff_echo_started", mon_busy, 1);
    repeat (BIT_CLK / 4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_tx_forced_high", tx, 1);
    exp_q.delete();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    k = 0;
    while (mon_busy && k < 12 * BIT_CLK) begin
      @(negedge clk);
      k++;
    end
    check("rst_monitor_idle", mon_busy, 0);
    check("rst_tx_idle", tx, 1);
    v42 = '{8'h42, 1'b1, 1, 1'b1};
    run_vec(v42, "after_rst_42");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
